// File: rtl/spi_flash_pkg.sv
// Shared types and constants for the SPI NOR flash responder: FSM states,
// opcodes and the JEDEC ID byte selector.
package spi_flash_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DUMMY,
        DATA,
        ID,
        IGNORE
    } state_t;

    localparam logic [7:0] OP_READ  = 8'h03;
    localparam logic [7:0] OP_FREAD = 8'h0B;
    localparam logic [7:0] OP_JEDEC = 8'h9F;
    localparam logic [7:0] OP_PD    = 8'hB9;
    localparam logic [7:0] OP_RPD   = 8'hAB;

    // Index 0..2 walks the ID MSB byte first; anything past it reads as zero.
    function automatic logic [7:0] jedec_byte(input logic [23:0] id, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = id[23:16];
            2'd1:    b = id[15:8];
            2'd2:    b = id[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/spi_flash_emulator_if.sv
// Single-I/O SPI flash pin bundle; the master drives select/clock/MOSI, the
// flash returns MISO plus its drive enable.
interface spi_flash_emulator_if;
    logic csb;
    logic sck;
    logic io0;
    logic io1_o;
    logic io1_oe;

    modport master (output csb, sck, io0, input io1_o, io1_oe);
    modport slave  (input csb, sck, io0, output io1_o, io1_oe);
endinterface

// File: rtl/spi_pin_sync.sv
// Brings csb/sck/io0 into the clk domain and produces single-cycle sck edge
// and csb fall strobes from the synchronized copies.
module spi_pin_sync (
    input  logic clk,
    input  logic rst,
    input  logic csb,
    input  logic sck,
    input  logic io0,
    output logic csb_s,
    output logic csb_fall,
    output logic sck_rise,
    output logic sck_fall,
    output logic io0_s
);

    logic [2:0] pins;
    logic [2:0] sync_vec;
    logic       csb_d_reg;
    logic       sck_d_reg;

    assign pins = {csb, sck, io0};

    // csb resets low on purpose: a select already low at reset release must not
    // look like a fresh fall, so the master has to deselect and reselect.
    for (genvar gi = 0; gi < 3; gi++) begin : g_sync
        logic meta_reg;
        logic sync_reg;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                meta_reg <= 1'b0;
                sync_reg <= 1'b0;
            end else begin
                meta_reg <= pins[gi];
                sync_reg <= meta_reg;
            end
        end

        assign sync_vec[gi] = sync_reg;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csb_d_reg <= 1'b0;
            sck_d_reg <= 1'b0;
        end else begin
            csb_d_reg <= sync_vec[2];
            sck_d_reg <= sync_vec[1];
        end
    end

    assign csb_s    = sync_vec[2];
    assign io0_s    = sync_vec[0];
    assign csb_fall = ~sync_vec[2] & csb_d_reg;
    assign sck_rise = sync_vec[1] & ~sck_d_reg;
    assign sck_fall = ~sync_vec[1] & sck_d_reg;

endmodule

// File: rtl/spi_flash_emulator.sv
// Read-only single-I/O SPI NOR flash model (mode 0) oversampled by clk:
// read, fast read, JEDEC ID, power-down and release from power-down.
module spi_flash_emulator
    import spi_flash_pkg::*;
#(
    parameter string       FILENAME  = "team_04.hex",
    parameter int          ADDR_BITS = 16,
    parameter logic [23:0] JEDEC_ID  = 24'hEF4018
) (
    input logic                 clk,
    input logic                 rst,
    spi_flash_emulator_if.slave spi
);

    logic csb_s, csb_fall, sck_rise, sck_fall, io0_s;

    spi_pin_sync u_sync (
        .clk      (clk),
        .rst      (rst),
        .csb      (spi.csb),
        .sck      (spi.sck),
        .io0      (spi.io0),
        .csb_s    (csb_s),
        .csb_fall (csb_fall),
        .sck_rise (sck_rise),
        .sck_fall (sck_fall),
        .io0_s    (io0_s)
    );

    logic [7:0] mem_reg [0:(2**ADDR_BITS)-1];
    logic [7:0] rd_data_reg;

    state_t      state_reg, state_next;
    logic [2:0]  bit_cnt_reg, bit_cnt_next;
    logic [1:0]  byte_cnt_reg, byte_cnt_next;
    logic [7:0]  shift_reg, shift_next;
    logic [23:0] addr_reg, addr_next;
    logic [7:0]  tx_reg, tx_next;
    logic        io1_o_reg, io1_o_next;
    logic        io1_oe_reg, io1_oe_next;
    logic        pd_reg, pd_next;
    logic [7:0]  cmd_byte;
    logic [7:0]  load_byte;

    // addr settles on an sck rise, so the registered read is ready long before
    // the following sck fall needs it.
    always_ff @(posedge clk) begin
        rd_data_reg <= mem_reg[addr_reg[ADDR_BITS-1:0]];
    end

    assign cmd_byte = {shift_reg[6:0], io0_s};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            bit_cnt_reg  <= 3'd0;
            byte_cnt_reg <= 2'd0;
            shift_reg    <= 8'h00;
            addr_reg     <= 24'h000000;
            tx_reg       <= 8'h00;
            io1_o_reg    <= 1'b0;
            io1_oe_reg   <= 1'b0;
            pd_reg       <= 1'b1;
        end else begin
            state_reg    <= state_next;
            bit_cnt_reg  <= bit_cnt_next;
            byte_cnt_reg <= byte_cnt_next;
            shift_reg    <= shift_next;
            addr_reg     <= addr_next;
            tx_reg       <= tx_next;
            io1_o_reg    <= io1_o_next;
            io1_oe_reg   <= io1_oe_next;
            pd_reg       <= pd_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        bit_cnt_next  = bit_cnt_reg;
        byte_cnt_next = byte_cnt_reg;
        shift_next    = shift_reg;
        addr_next     = addr_reg;
        tx_next       = tx_reg;
        io1_o_next    = io1_o_reg;
        io1_oe_next   = io1_oe_reg;
        pd_next       = pd_reg;
        load_byte     = 8'h00;

        // Deselect outranks any sck edge seen in the same cycle.
        if (csb_s) begin
            state_next    = IDLE;
            bit_cnt_next  = 3'd0;
            byte_cnt_next = 2'd0;
            shift_next    = 8'h00;
            io1_o_next    = 1'b0;
            io1_oe_next   = 1'b0;
        end else if (state_reg == IDLE) begin
            if (csb_fall) begin
                state_next    = CMD;
                bit_cnt_next  = 3'd0;
                byte_cnt_next = 2'd0;
            end
        end else if (sck_rise) begin
            bit_cnt_next = bit_cnt_reg + 3'd1;
            case (state_reg)
                CMD: begin
                    shift_next = cmd_byte;
                    if (bit_cnt_reg == 3'd7) begin
                        if (cmd_byte == OP_RPD) begin
                            pd_next    = 1'b0;
                            state_next = IGNORE;
                        end else if (pd_reg) begin
                            state_next = IGNORE;
                        end else begin
                            case (cmd_byte)
                                OP_PD: begin
                                    pd_next    = 1'b1;
                                    state_next = IGNORE;
                                end
                                OP_READ, OP_FREAD: state_next = ADDR;
                                OP_JEDEC:          state_next = ID;
                                default:           state_next = IGNORE;
                            endcase
                        end
                    end
                end
                ADDR: begin
                    addr_next = {addr_reg[22:0], io0_s};
                    if (bit_cnt_reg == 3'd7) begin
                        if (byte_cnt_reg == 2'd2) begin
                            byte_cnt_next = 2'd0;
                            state_next    = (shift_reg == OP_FREAD) ? DUMMY : DATA;
                        end else begin
                            byte_cnt_next = byte_cnt_reg + 2'd1;
                        end
                    end
                end
                DUMMY: begin
                    if (bit_cnt_reg == 3'd7) state_next = DATA;
                end
                DATA: begin
                    if (bit_cnt_reg == 3'd7) addr_next = addr_reg + 24'd1;
                end
                ID: begin
                    if (bit_cnt_reg == 3'd7 && byte_cnt_reg != 2'd3)
                        byte_cnt_next = byte_cnt_reg + 2'd1;
                end
                default: ;
            endcase
        end else if (sck_fall && (state_reg == DATA || state_reg == ID)) begin
            io1_oe_next = 1'b1;
            if (bit_cnt_reg == 3'd0) begin
                load_byte  = (state_reg == DATA) ? rd_data_reg
                                                 : jedec_byte(JEDEC_ID, byte_cnt_reg);
                io1_o_next = load_byte[7];
                tx_next    = {load_byte[6:0], 1'b0};
            end else begin
                io1_o_next = tx_reg[7];
                tx_next    = {tx_reg[6:0], 1'b0};
            end
        end
    end

    assign spi.io1_o  = io1_o_reg;
    assign spi.io1_oe = io1_oe_reg;

endmodule

// File: tb/tb_spi_flash_emulator.sv
// Scoreboard bench for the SPI flash responder: a driver issues randomized
// transactions and queues expected bytes, a monitor checks what the flash returns.
module tb_spi_flash_emulator;

    localparam int          HALF  = 50;
    localparam int          DEPTH = 65536;
    localparam logic [23:0] JID   = 24'hEF4018;

    logic clk;
    logic rst;

    spi_flash_emulator_if spi ();

    spi_flash_emulator #(
        .FILENAME  (""),
        .ADDR_BITS (16),
        .JEDEC_ID  (JID)
    ) dut (
        .clk (clk),
        .rst (rst),
        .spi (spi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    logic [7:0] model_mem [0:DEPTH-1];
    bit   model_pd;
    logic [7:0] exp_q [$];
    logic [7:0] rx_byte;
    int   rx_bits;
    bit   oe_seen;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: behaves as the SPI master's receiver, sampling MISO on sck rise.
    always @(posedge spi.sck) begin
        if (!spi.csb && spi.io1_oe) begin
            oe_seen = 1'b1;
            rx_byte = {rx_byte[6:0], spi.io1_o};
            rx_bits++;
            if (rx_bits == 8) begin
                rx_bits = 0;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_byte: got %0h expected none", rx_byte);
                end else begin
                    check("rx_byte", {24'h0, rx_byte}, {24'h0, exp_q.pop_front()});
                end
            end
        end
    end

    always @(posedge spi.csb) rx_bits = 0;

    task automatic spi_bit(input logic b);
        spi.io0 = b;
        #HALF spi.sck = 1'b1;
        #HALF spi.sck = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) spi_bit(b[i]);
    endtask

    task automatic cs_low();
        oe_seen = 1'b0;
        spi.csb = 1'b0;
        #HALF;
    endtask

    task automatic cs_high();
        #HALF spi.csb = 1'b1;
        #(HALF * 3);
    endtask

    task automatic send_addr(input logic [23:0] a);
        spi_byte(a[23:16]);
        spi_byte(a[15:8]);
        spi_byte(a[7:0]);
    endtask

    // Model: a powered-down flash drives nothing; otherwise bytes come from
    // consecutive addresses taken modulo the memory depth.
    task automatic do_read(input bit fast, input logic [23:0] a, input int n);
        cs_low();
        spi_byte(fast ? 8'h0B : 8'h03);
        send_addr(a);
        if (fast) spi_byte(8'($urandom));
        check(fast ? "fread_preamble_oe" : "read_preamble_oe", {31'h0, oe_seen}, 32'h0);
        if (!model_pd)
            for (int i = 0; i < n; i++) exp_q.push_back(model_mem[(int'(a) + i) % DEPTH]);
        for (int i = 0; i < n; i++) spi_byte(8'($urandom));
        cs_high();
        check("read_drive", {31'h0, oe_seen}, {31'h0, !model_pd});
    endtask

    task automatic do_jedec(input int n);
        cs_low();
        spi_byte(8'h9F);
        if (!model_pd)
            for (int i = 0; i < n; i++)
                exp_q.push_back(i < 3 ? 8'((JID >> (8 * (2 - i))) & 24'hFF) : 8'h00);
        for (int i = 0; i < n; i++) spi_byte(8'($urandom));
        cs_high();
        check("jedec_drive", {31'h0, oe_seen}, {31'h0, !model_pd});
    endtask

    task automatic do_cmd(input logic [7:0] op);
        cs_low();
        spi_byte(op);
        cs_high();
        if (op == 8'hAB) model_pd = 1'b0;
        else if (op == 8'hB9) model_pd = 1'b1;
        check("cmd_oe", {31'h0, oe_seen}, 32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b1;
        spi.csb = 1'b1;
        spi.sck = 1'b0;
        spi.io0 = 1'b0;
        rx_bits = 0;
        rx_byte = 8'h00;
        oe_seen = 1'b0;
        model_pd = 1'b1;
        #1;
        for (int i = 0; i < DEPTH; i++) begin
            model_mem[i]   = 8'($urandom);
            dut.mem_reg[i] = model_mem[i];
        end
        #30;
        check("reset_oe", {31'h0, spi.io1_oe}, 32'h0);
        check("reset_o", {31'h0, spi.io1_o}, 32'h0);
        #21 rst = 1'b0;
        #100;

        // Directed scenarios.
        do_read(1'b0, 24'h000000, 4);
        do_cmd(8'hAB);
        do_read(1'b0, 24'h000000, 4);
        do_read(1'b1, 24'h000010, 2);
        do_read(1'b0, 24'h00FFFF, 2);
        do_jedec(4);
        do_cmd(8'hB9);
        do_jedec(4);
        do_cmd(8'hAB);

        // Abort after three data bits.
        cs_low();
        spi_byte(8'h03);
        send_addr(24'h001234);
        for (int i = 0; i < 3; i++) spi_bit(1'b0);
        check("abort_pre_oe", {31'h0, spi.io1_oe}, 32'h1);
        #HALF spi.csb = 1'b1;
        repeat (4) @(posedge clk);
        #1 check("abort_oe", {31'h0, spi.io1_oe}, 32'h0);
        #(HALF * 2);
        do_read(1'b0, 24'h001234, 2);

        // Reset in the middle of a read.
        cs_low();
        spi_byte(8'h03);
        send_addr(24'h00ABCD);
        exp_q.push_back(model_mem[16'hABCD]);
        spi_byte(8'h00);
        for (int i = 0; i < 3; i++) spi_bit(1'b0);
        @(negedge clk) rst = 1'b1;
        #1;
        check("rst_oe", {31'h0, spi.io1_oe}, 32'h0);
        check("rst_o", {31'h0, spi.io1_o}, 32'h0);
        #20 rst = 1'b0;
        model_pd = 1'b1;
        #HALF spi.csb = 1'b1;
        #(HALF * 3);
        do_cmd(8'hAB);
        do_read(1'b0, 24'h00ABCD, 3);

        // Randomized traffic.
        for (int t = 0; t < 24; t++) begin
            int kind;
            kind = $urandom_range(0, 7);
            case (kind)
                0, 1, 2: do_read(1'b0, 24'($urandom), $urandom_range(1, 4));
                3, 4:    do_read(1'b1, 24'($urandom), $urandom_range(1, 4));
                5:       do_jedec($urandom_range(1, 5));
                6:       do_cmd(($urandom_range(0, 1) == 1) ? 8'hAB : 8'hB9);
                default: do_cmd(8'($urandom));
            endcase
        end

        check("queue_drained", exp_q.size(), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
